// File: rtl/llc_output_encoder_pkg.sv
// llc_output_encoder_pkg
// Shared types and constants for the LLC outbound encoder: the payload
// structs for the rsp_out, fwd_out and mem_req channels and the default
// queue depth of each channel.
package llc_output_encoder_pkg;

  localparam int LLC_RSP_OUT_Q_DEPTH = 2;
  localparam int LLC_FWD_OUT_Q_DEPTH = 2;
  localparam int LLC_MEM_REQ_Q_DEPTH = 2;

  typedef struct packed {
    logic [2:0]   coh_msg;
    logic [31:0]  addr;
    logic [127:0] line;
    logic [3:0]   word_mask;
    logic [3:0]   req_id;
    logic [3:0]   dest_id;
  } llc_rsp_out_t;

  typedef struct packed {
    logic [2:0]  coh_msg;
    logic [31:0] addr;
    logic [3:0]  req_id;
    logic [3:0]  dest_id;
    logic [3:0]  word_mask;
  } llc_fwd_out_t;

  typedef struct packed {
    logic         hwrite;
    logic [2:0]   hsize;
    logic [1:0]   hprot;
    logic [31:0]  addr;
    logic [127:0] line;
  } llc_mem_req_t;

endpackage

// File: rtl/llc_out_fifo.sv
// llc_out_fifo
// One outbound channel: a circular buffer of DEPTH entries of type T that
// drives a valid/ready interface from its head entry.
//
// Handshake: valid is asserted while an entry is available and the head
// payload is held stable until the cycle where valid && ready, at whose
// clock edge the entry is popped. ready may stay low indefinitely.
//
// Build option LLC_OUT_BYPASS_EN: a push into an empty FIFO is shown on
// the interface in the same cycle; if ready is high it is consumed there
// and never stored. Without it, a push is visible one cycle later.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, data_in   enqueue request and payload
//   ready        interface ready
//   valid, data_out interface valid and head payload
//   full         stored count == DEPTH
//   empty        stored count == 0
//   dropped      push refused because the FIFO was full with no pop
module llc_out_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     data_in,
  input  logic ready,
  output logic valid,
  output T     data_out,
  output logic full,
  output logic empty,
  output logic dropped
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  logic stored;
  logic pop;
  logic accept;
  logic byp;
  logic wr;

  // Explicit wrap so non-power-of-2 depths stay inside the array.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stored = (count != '0);
  assign pop    = stored && ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && ((count != CW'(DEPTH)) || pop);

`ifdef LLC_OUT_BYPASS_EN
  assign byp      = push && !stored && ready;
  assign valid    = stored || push;
  assign data_out = stored ? mem[rd_ptr] : data_in;
`else
  assign byp      = 1'b0;
  assign valid    = stored;
  assign data_out = mem[rd_ptr];
`endif

  assign wr      = accept && !byp;
  assign full    = (count == CW'(DEPTH));
  assign empty   = !stored;
  assign dropped = push && !accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/llc_output_encoder.sv
// llc_output_encoder
// Outbound side of the LLC: buffers send commands from the LLC FSM on the
// rsp_out (to L2), fwd_out (to L2 owners) and mem_req (to memory) channels
// and drives each onto its own valid/ready interface. Channels are fully
// independent; each is strictly FIFO-ordered, which keeps a writeback
// mem_req ahead of a later read of the same line.
//
// Build option LLC_OUT_BYPASS_EN: same-cycle bypass of a push into an
// empty channel (see llc_out_fifo). Full and idle flags are the same in
// both builds.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   send_*, *_payload_in            FSM push and payload per channel
//   llc_*_ready_int                 interface ready per channel
//   llc_*_valid_int, llc_*_o        interface valid and head payload
//   rsp_out_full/fwd_out_full/mem_req_full  channel holds DEPTH entries
//   out_idle                        all channels empty
//   overflow_err                    sticky: a push was dropped on a full
//                                   channel; cleared only by reset
module llc_output_encoder
  import llc_output_encoder_pkg::*;
#(
  parameter int RSP_Q_DEPTH = LLC_RSP_OUT_Q_DEPTH,
  parameter int FWD_Q_DEPTH = LLC_FWD_OUT_Q_DEPTH,
  parameter int MEM_Q_DEPTH = LLC_MEM_REQ_Q_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send_rsp_out,
  input  llc_rsp_out_t rsp_out_payload_in,
  input  logic         send_fwd_out,
  input  llc_fwd_out_t fwd_out_payload_in,
  input  logic         send_mem_req,
  input  llc_mem_req_t mem_req_payload_in,
  input  logic         llc_rsp_out_ready_int,
  input  logic         llc_fwd_out_ready_int,
  input  logic         llc_mem_req_ready_int,
  output logic         llc_rsp_out_valid_int,
  output llc_rsp_out_t llc_rsp_out_o,
  output logic         llc_fwd_out_valid_int,
  output llc_fwd_out_t llc_fwd_out_o,
  output logic         llc_mem_req_valid_int,
  output llc_mem_req_t llc_mem_req_o,
  output logic         rsp_out_full,
  output logic         fwd_out_full,
  output logic         mem_req_full,
  output logic         out_idle,
  output logic         overflow_err
);

  logic rsp_empty, fwd_empty, mem_empty;
  logic rsp_drop, fwd_drop, mem_drop;

  llc_out_fifo #(.DEPTH(RSP_Q_DEPTH), .T(llc_rsp_out_t)) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (send_rsp_out),
    .data_in  (rsp_out_payload_in),
    .ready    (llc_rsp_out_ready_int),
    .valid    (llc_rsp_out_valid_int),
    .data_out (llc_rsp_out_o),
    .full     (rsp_out_full),
    .empty    (rsp_empty),
    .dropped  (rsp_drop)
  );

  llc_out_fifo #(.DEPTH(FWD_Q_DEPTH), .T(llc_fwd_out_t)) u_fwd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (send_fwd_out),
    .data_in  (fwd_out_payload_in),
    .ready    (llc_fwd_out_ready_int),
    .valid    (llc_fwd_out_valid_int),
    .data_out (llc_fwd_out_o),
    .full     (fwd_out_full),
    .empty    (fwd_empty),
    .dropped  (fwd_drop)
  );

  llc_out_fifo #(.DEPTH(MEM_Q_DEPTH), .T(llc_mem_req_t)) u_mem_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (send_mem_req),
    .data_in  (mem_req_payload_in),
    .ready    (llc_mem_req_ready_int),
    .valid    (llc_mem_req_valid_int),
    .data_out (llc_mem_req_o),
    .full     (mem_req_full),
    .empty    (mem_empty),
    .dropped  (mem_drop)
  );

  // Derived only from stored counts, so the FSM sees no path from send/ready.
  assign out_idle = rsp_empty && fwd_empty && mem_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               overflow_err <= 1'b0;
    else if (rsp_drop || fwd_drop || mem_drop) overflow_err <= 1'b1;
  end

endmodule
